fetch_prefetch: RTL



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_prefetch_instr_queue.sv | 61 ++++++
 rtl/fetch_prefetch.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the prefetching fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Memory controller host-port opcodes
  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  // Instruction presented to decode when nothing meaningful is available
  localparam logic [31:0] NOP = 32'h7800_0000;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0600_2000;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_instr_queue.sv
// Synchronous FIFO holding {pc, instr} pairs between the line buffer and decode.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full (even with a same-cycle pop); pop ignored when empty; clear wins.
// Ports: clk/rst, push/push_dat, pop, clear, head_dat, full, empty.
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head_dat = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_dat;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: owns the PC, reads whole lines from the host port, feeds decode one instruction per cycle.
// Latency: line data arriving in cycle M is pushed at the end of M+1 and is valid at decode in M+2.
// Backpressure: stall holds the queue head; a full queue stops PC advance; injections never pop.
// Ports: redirect/restore reload the PC; stall/injections shape the decode side;
//        *_host is the memory controller read port (line-aligned, read only).
module fetch_prefetch import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          LINE_BITS   = 512,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 restore,
  input  logic [31:0]          PC_before_int,
  input  logic                 stall,
  input  logic                 use_cpu_injection,
  input  logic [31:0]          cpu_injection,
  input  logic                 use_INT_INSTR,
  input  logic [31:0]          INT_INSTR,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [31:0]          current_PC,
  input  logic [LINE_BITS-1:0] DataIn_host,
  input  logic                 rd_valid_host,
  input  logic                 tx_done_host,
  output logic [LINE_BITS-1:0] DataOut_host,
  output logic [31:0]          AddrOut_host,
  output logic [1:0]           op_host
);

  localparam int INSTRS = LINE_BITS / 32;
  localparam int OFF    = $clog2(LINE_BITS / 8);
  localparam int IW     = $clog2(INSTRS);

  fetch_state_t                state_q, state_d;
  logic [31:0]                 fetch_pc_q, fetch_pc_d;
  logic [31:0]                 addr_q, addr_d;
  logic [INSTRS-1:0][31:0]     line_q, line_d;
  logic [31:OFF]               tag_q, tag_d;
  logic                        line_vld_q, line_vld_d;

  logic        flush, hit, inj;
  logic [31:0] flush_pc;
  logic [IW-1:0] word_idx;
  logic        q_push, q_pop, q_full, q_empty;
  logic [63:0] q_push_dat, q_head;

  instr_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (64)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_dat (q_push_dat),
    .pop      (q_pop),
    .clear    (flush),
    .head_dat (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_comb begin
    flush      = restore | redirect;
    flush_pc   = restore ? PC_before_int : redirect_pc;
    hit        = line_vld_q && (tag_q == fetch_pc_q[31:OFF]);
    inj        = use_cpu_injection | use_INT_INSTR;
    word_idx   = fetch_pc_q[OFF-1:2];
    q_push     = hit && !q_full && !flush;
    q_push_dat = {fetch_pc_q, line_q[word_idx]};
    q_pop      = !q_empty && !stall && !inj;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    line_d     = line_q;
    tag_d      = tag_q;
    line_vld_d = line_vld_q;

    case (state_q)
      // A flush always leaves the buffer invalid, so it is a guaranteed miss:
      // go straight to READ so the new line is requested the very next cycle.
      IDLE: if (flush || !hit) state_d = READ;
      READ: begin
        if (rd_valid_host && !flush) begin
          line_d     = DataIn_host;
          tag_d      = addr_q[31:OFF];
          line_vld_d = 1'b1;
        end
        if (tx_done_host)  state_d = IDLE;
        else if (flush)    state_d = DRAIN;
      end
      DRAIN: if (tx_done_host) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      line_vld_d = 1'b0;
      fetch_pc_d = flush_pc;
    end else if (q_push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // Address is latched on entry to READ so later PC advance (once the line
    // lands mid-transaction) cannot move it while the request is open.
    if (state_d != READ)       addr_d = '0;
    else if (state_q == READ)  addr_d = addr_q;
    else                       addr_d = {fetch_pc_d[31:OFF], {OFF{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      line_q     <= '0;
      tag_q      <= '0;
      line_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
      tag_q      <= tag_d;
      line_vld_q <= line_vld_d;
    end
  end

  always_comb begin
    instr       = NOP;
    instr_valid = 1'b0;
    if (use_cpu_injection) begin
      instr       = cpu_injection;
      instr_valid = 1'b1;
    end else if (use_INT_INSTR) begin
      instr       = INT_INSTR;
      instr_valid = 1'b1;
    end else if (!flush && !q_empty) begin
      instr       = q_head[31:0];
      instr_valid = 1'b1;
    end
    // With an empty queue the next head will be the fetch PC
    current_PC   = q_empty ? fetch_pc_q : q_head[63:32];
    op_host      = (state_q == READ) ? OP_READ : OP_IDLE;
    AddrOut_host = addr_q;
    DataOut_host = '0;
  end

endmodule
